reg_writer: RTL and testbench

- Transmit side of the 4-bit lookup-register load interface.
- Accepts (index, value) write requests over a valid/ready handshake and buffers them in a small FIFO.
- Serialises each request onto the shared newd/setd bus as a two-beat frame:
  - address nibble {1'b1, idx};
  - then the data nibble.
- Drives the 8-entry register bank that captures values addressed 4'b1000..4'b1111.

---
 rtl/reg_if_pkg.sv | 25 ++
 rtl/reg_writer_fifo.sv | 54 +++++
 rtl/reg_writer.sv | 157 +++++++++++++++
 tb/tb_reg_writer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_if_pkg.sv
// Shared types for the lookup-register load interface.
// Frame states, request bundle and address-beat helper.
package reg_if_pkg;

   localparam logic ADDR_TAG = 1'b1;
   localparam int   NUM_REGS = 8;
   localparam int   IDX_W    = $clog2(NUM_REGS);

   typedef enum logic [1:0] {
      IDLE,
      ADDR,
      DATA,
      GAP
   } wr_state_e;

   typedef struct packed {
      logic [IDX_W-1:0] idx;
      logic [3:0]       data;
   } wr_req_t;

   function automatic logic [3:0] addr_nibble(input logic [IDX_W-1:0] idx);
      return {ADDR_TAG, idx};
   endfunction

endpackage

// File: rtl/reg_writer_fifo.sv
// wr_fifo: synchronous request FIFO of wr_req_t, cleared by init.
// Push while full and pop while empty are ignored.
module wr_fifo
   import reg_if_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic    clk,
   input  logic    init,
   input  logic    push_i,
   input  wr_req_t din_i,
   input  logic    pop_i,
   output wr_req_t dout_o,
   output logic    full_o,
   output logic    empty_o
);

   localparam int AW = $clog2(DEPTH);

   wr_req_t     mem_q [DEPTH];
   logic [AW:0] wr_ptr_q;
   logic [AW:0] rd_ptr_q;
   logic        do_push;
   logic        do_pop;

   // Extra pointer bit separates full from empty when the indices match.
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;
   assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= din_i;
      end
   end

   always_ff @(posedge clk) begin
      if (init) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
         end
      end
   end

endmodule

// File: rtl/reg_writer.sv
// reg_writer: serialises buffered (idx, data) writes onto the newd/setd bus.
// Define REG_WRITER_FILL_EN to add the fill_start/fill_value bulk fill.
module reg_writer
   import reg_if_pkg::*;
#(
   parameter int DEPTH      = 4,
   parameter int GAP_CYCLES = 1
) (
   input  logic       clk,
   input  logic       init,
`ifdef REG_WRITER_FILL_EN
   input  logic       fill_start,
   input  logic [3:0] fill_value,
`endif
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [2:0] req_idx,
   input  logic [3:0] req_data,
   output logic       setd,
   output logic [3:0] newd,
   output logic       busy,
   output logic [7:0] sent_count
);

   wr_state_e  state_q;
   wr_req_t    frame_q;
   wr_req_t    head;
   wr_req_t    wr_req;
   wr_req_t    launch_req;
   logic       setd_q;
   logic [3:0] newd_q;
   logic [7:0] sent_q;
   logic [2:0] gap_q;
   logic       full;
   logic       empty;
   logic       push;
   logic       pop;
   logic       launch;
   logic       fill_busy;

   assign wr_req     = '{idx: req_idx, data: req_data};
   assign req_ready  = ~full & ~init & ~fill_busy;
   assign push       = req_valid & req_ready;
   assign pop        = (state_q == IDLE) & ~empty & ~fill_busy & ~init;
   assign busy       = ~empty | (state_q != IDLE) | fill_busy;
   assign setd       = setd_q;
   assign newd       = newd_q;
   assign sent_count = sent_q;

   wr_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk    (clk),
      .init   (init),
      .push_i (push),
      .din_i  (wr_req),
      .pop_i  (pop),
      .dout_o (head),
      .full_o (full),
      .empty_o(empty)
   );

`ifdef REG_WRITER_FILL_EN
   logic       fill_q;
   logic [2:0] fill_idx_q;
   logic [3:0] fill_val_q;
   logic       fill_go;

   assign fill_busy = fill_q;
   assign fill_go   = (state_q == IDLE) & empty & ~fill_q & fill_start;

   // Fill frames take the bus ahead of the FIFO, which is held off anyway.
   always_comb begin
      launch     = pop | fill_go | ((state_q == IDLE) & fill_q);
      launch_req = head;
      if (fill_q) begin
         launch_req = '{idx: fill_idx_q, data: fill_val_q};
      end else if (fill_go) begin
         launch_req = '{idx: '0, data: fill_value};
      end
   end

   always_ff @(posedge clk) begin
      if (init) begin
         fill_q     <= 1'b0;
         fill_idx_q <= '0;
         fill_val_q <= '0;
      end else if (fill_go) begin
         fill_q     <= 1'b1;
         fill_idx_q <= 3'd1;
         fill_val_q <= fill_value;
      end else if (fill_q) begin
         if (state_q == IDLE) begin
            fill_idx_q <= fill_idx_q + 3'd1;
         end
         if ((state_q == DATA) && (frame_q.idx == 3'(NUM_REGS - 1))) begin
            fill_q <= 1'b0;
         end
      end
   end
`else
   assign fill_busy  = 1'b0;
   assign launch     = pop;
   assign launch_req = head;
`endif

   always_ff @(posedge clk) begin
      if (init) begin
         state_q <= IDLE;
         frame_q <= '0;
         setd_q  <= 1'b0;
         newd_q  <= 4'h0;
         sent_q  <= 8'd0;
         gap_q   <= 3'd0;
      end else begin
         unique case (state_q)
            IDLE: begin
               setd_q <= 1'b0;
               newd_q <= 4'h0;
               if (launch) begin
                  state_q <= ADDR;
                  frame_q <= launch_req;
                  setd_q  <= 1'b1;
                  newd_q  <= addr_nibble(launch_req.idx);
               end
            end
            ADDR: begin
               state_q <= DATA;
               setd_q  <= 1'b1;
               newd_q  <= frame_q.data;
            end
            DATA: begin
               sent_q  <= sent_q + 8'd1;
               setd_q  <= 1'b0;
               newd_q  <= 4'h0;
               gap_q   <= 3'd0;
               state_q <= (GAP_CYCLES > 0) ? GAP : IDLE;
            end
            GAP: begin
               setd_q <= 1'b0;
               newd_q <= 4'h0;
               if (gap_q == 3'(GAP_CYCLES - 1)) begin
                  state_q <= IDLE;
               end else begin
                  gap_q <= gap_q + 3'd1;
               end
            end
            default: begin
               state_q <= IDLE;
               setd_q  <= 1'b0;
               newd_q  <= 4'h0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_reg_writer.sv
// Self-checking bench for reg_writer: slot-based bus model plus pinned literals.
// Define REG_WRITER_FILL_EN to also exercise the bulk fill.
`timescale 1ns/1ps
module tb_reg_writer;

   localparam int DEPTH = 4;
   localparam int GAPC  = 1;
   // A frame occupies ADDR, DATA, GAPC low cycles and one IDLE cycle.
   localparam int L     = 3 + GAPC;

   typedef struct packed {
      logic [2:0] idx;
      logic [3:0] data;
   } fr_t;

   logic       clk = 1'b0;
   logic       init = 1'b1;
   logic       req_valid = 1'b0;
   logic [2:0] req_idx = '0;
   logic [3:0] req_data = '0;
   logic       req_ready;
   logic       setd;
   logic [3:0] newd;
   logic       busy;
   logic [7:0] sent_count;
`ifdef REG_WRITER_FILL_EN
   logic       fill_start = 1'b0;
   logic [3:0] fill_value = '0;
`endif

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   reg_writer #(
      .DEPTH     (DEPTH),
      .GAP_CYCLES(GAPC)
   ) dut (
      .clk       (clk),
      .init      (init),
`ifdef REG_WRITER_FILL_EN
      .fill_start(fill_start),
      .fill_value(fill_value),
`endif
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_idx   (req_idx),
      .req_data  (req_data),
      .setd      (setd),
      .newd      (newd),
      .busy      (busy),
      .sent_count(sent_count)
   );

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: pending queue, current frame and position in its slot.
   fr_t pend[$];
   fr_t fillq[$];
   fr_t cur = '0;
   bit  cur_fill = 1'b0;
   int  pos = L - 1;
   int  sent = 0;

   function automatic bit m_fill_act();
      return (fillq.size() > 0) || (cur_fill && pos <= 1);
   endfunction

   function automatic bit m_ready();
      return (pend.size() < DEPTH) && !init && !m_fill_act();
   endfunction

   always @(posedge clk) begin : model
      bit  push_ok;
      fr_t nf;
      push_ok = req_valid && m_ready();
      nf.idx  = req_idx;
      nf.data = req_data;
      if (init) begin
         pend.delete();
         fillq.delete();
         cur_fill = 1'b0;
         pos      = L - 1;
         sent     = 0;
      end else begin
         if (pos == 1) sent = (sent + 1) % 256;
         if (pos < L - 1) begin
            pos++;
         end else if (fillq.size() > 0) begin
            cur      = fillq.pop_front();
            cur_fill = 1'b1;
            pos      = 0;
         end else if (pend.size() > 0) begin
            cur      = pend.pop_front();
            cur_fill = 1'b0;
            pos      = 0;
         end
`ifdef REG_WRITER_FILL_EN
         else if (fill_start) begin
            for (int k = 1; k < 8; k++) begin
               fr_t ff;
               ff.idx  = 3'(k);
               ff.data = fill_value;
               fillq.push_back(ff);
            end
            cur.idx  = 3'd0;
            cur.data = fill_value;
            cur_fill = 1'b1;
            pos      = 0;
         end
`endif
         if (push_ok) pend.push_back(nf);
      end
   end

   always @(negedge clk) begin : compare
      logic [3:0] exp_newd;
      if (chk_en) begin
         exp_newd = (pos == 0) ? {1'b1, cur.idx} :
                    (pos == 1) ? cur.data : 4'h0;
         check("setd", setd, (pos <= 1));
         check("newd", newd, exp_newd);
         check("busy", busy,
               (pend.size() > 0) || (pos < L - 1) || (fillq.size() > 0));
         check("req_ready", req_ready, m_ready());
         check("sent_count", sent_count, sent);
      end
   end

   // Called at posedge+2; returns at posedge+2 after the accepting edge.
   task automatic push(input logic [2:0] i, input logic [3:0] d);
      int n = 0;
      bit acc = 1'b0;
      req_valid = 1'b1;
      req_idx   = i;
      req_data  = d;
      do begin
         @(negedge clk);
         acc = req_ready;
         @(posedge clk);
         #2;
         n++;
      end while (!acc && n < 200);
      check("push_accept", acc, 1'b1);
      req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      bit b = 1'b1;
      do begin
         @(negedge clk);
         b = busy;
         @(posedge clk);
         #2;
         n++;
      end while (b && n < 3000);
      check("idle_timeout", b, 1'b0);
   endtask

   initial begin
      int n;
      @(posedge clk);
      #2 chk_en = 1'b1;
      @(negedge clk);
      check("rst_setd", setd, 1'b0);
      check("rst_newd", newd, 4'h0);
      check("rst_sent", sent_count, 8'd0);
      check("rst_busy", busy, 1'b0);
      check("rst_ready", req_ready, 1'b0);
      @(posedge clk);
      #2 init = 1'b0;

      // Single write: exact bus sequence.
      push(3'd3, 4'hA);
      @(negedge clk);
      check("sw_idle_setd", setd, 1'b0);
      @(negedge clk);
      check("sw_addr_setd", setd, 1'b1);
      check("sw_addr_newd", newd, 4'b1011);
      @(negedge clk);
      check("sw_data_setd", setd, 1'b1);
      check("sw_data_newd", newd, 4'hA);
      @(negedge clk);
      check("sw_after_setd", setd, 1'b0);
      check("sw_after_newd", newd, 4'h0);
      @(posedge clk);
      #2;
      wait_idle();
      check("sw_sent", sent_count, 8'd1);

      // Burst of four.
      for (int i = 0; i < 4; i++) push(3'(i), 4'(5 + i));
      wait_idle();
      check("burst_sent", sent_count, 8'd5);

      // Overfill: later pushes stall on req_ready.
      for (int i = 0; i < 6; i++) push(3'(i), 4'(i + 9));
      wait_idle();
      check("full_sent", sent_count, 8'd11);

      // Random traffic.
      repeat (400) begin
         req_valid = 1'($urandom_range(0, 1));
         req_idx   = 3'($urandom_range(0, 7));
         req_data  = 4'($urandom_range(0, 15));
         @(posedge clk);
         #2;
      end
      req_valid = 1'b0;
      wait_idle();

      // Reset during the ADDR beat of idx 6.
      push(3'd6, 4'hC);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (setd !== 1'b1 && n < 20);
      check("mid_addr_newd", newd, 4'hE);
      #1 init = 1'b1;
      @(posedge clk);
      #2 init = 1'b0;
      @(negedge clk);
      check("mid_setd", setd, 1'b0);
      check("mid_newd", newd, 4'h0);
      check("mid_sent", sent_count, 8'd0);
      check("mid_busy", busy, 1'b0);
      @(negedge clk);
      check("mid_no_data", setd, 1'b0);
      @(posedge clk);
      #2;

      // Counter wrap.
      for (int k = 0; k < 255; k++) push(3'(k % 8), 4'(k % 16));
      wait_idle();
      check("wrap_255", sent_count, 8'd255);
      push(3'd5, 4'h3);
      wait_idle();
      check("wrap_0", sent_count, 8'd0);

`ifdef REG_WRITER_FILL_EN
      fill_value = 4'h7;
      fill_start = 1'b1;
      @(posedge clk);
      #2 fill_start = 1'b0;
      @(negedge clk);
      check("fill_addr0", newd, 4'h8);
      check("fill_ready", req_ready, 1'b0);
      @(negedge clk);
      check("fill_data0", newd, 4'h7);
      @(posedge clk);
      #2;
      push(3'd2, 4'h1);
      wait_idle();
      check("fill_sent", sent_count, 8'd9);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
